// File: rtl/shift_reg_bank_pkg.sv
// shift_reg_bank_pkg
//   Shared definitions for the shift_reg_bank register bank.
//   mode_e : per-edge operation selected by the 2-bit mode input
//            (hold / forward shift / reverse shift / parallel load).
package shift_reg_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage : shift_reg_bank_pkg

// File: rtl/shift_reg_bank_if.sv
// shift_reg_bank_if
//   Control/data bundle for shift_reg_bank.
//   master modport : block driving the bank (en, clr, mode, sin_fwd, sin_rev, pload)
//   slave  modport : the bank itself (q_fwd, q_rev, v_fwd, v_rev, count, full, empty)
//   Optional: SHIFT_REG_BANK_TAP_EN adds taps / tap_valid (per-stage data and valid).
interface shift_reg_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                    en;
  logic                    clr;
  logic [1:0]              mode;
  logic [WIDTH-1:0]        sin_fwd;
  logic [WIDTH-1:0]        sin_rev;
  logic [WIDTH*DEPTH-1:0]  pload;

  logic [WIDTH-1:0]        q_fwd;
  logic [WIDTH-1:0]        q_rev;
  logic                    v_fwd;
  logic                    v_rev;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
`ifdef SHIFT_REG_BANK_TAP_EN
  logic [WIDTH*DEPTH-1:0]  taps;
  logic [DEPTH-1:0]        tap_valid;
`endif

  modport master (
    output en, clr, mode, sin_fwd, sin_rev, pload,
    input  q_fwd, q_rev, v_fwd, v_rev, count, full, empty
`ifdef SHIFT_REG_BANK_TAP_EN
    , input taps, tap_valid
`endif
  );

  modport slave (
    input  en, clr, mode, sin_fwd, sin_rev, pload,
    output q_fwd, q_rev, v_fwd, v_rev, count, full, empty
`ifdef SHIFT_REG_BANK_TAP_EN
    , output taps, tap_valid
`endif
  );

endinterface : shift_reg_bank_if

// File: rtl/shift_reg_bank_shift_stage.sv
// shift_stage
//   One data+valid stage of shift_reg_bank: D-register with async active-low
//   reset, synchronous clear, clock enable and a 4-way next-state mux.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     clr_i               synchronous clear (beats en_i and mode_i)
//     en_i                clock enable (0 = hold)
//     mode_i              hold / take fwd neighbour / take rev neighbour / load
//     fwd_data_i/valid_i  lower-index neighbour (or sin_fwd at stage 0)
//     rev_data_i/valid_i  higher-index neighbour (or sin_rev at last stage)
//     load_data_i         parallel-load word for this stage
//     data_o, valid_o     registered stage contents
module shift_stage
  import shift_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] fwd_data_i,
  input  logic             fwd_valid_i,
  input  logic [WIDTH-1:0] rev_data_i,
  input  logic             rev_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      unique case (mode_i)
        MODE_FWD: begin
          data_d  = fwd_data_i;
          valid_d = fwd_valid_i;
        end
        MODE_REV: begin
          data_d  = rev_data_i;
          valid_d = rev_valid_i;
        end
        MODE_LOAD: begin
          data_d  = load_data_i;
          valid_d = 1'b1;
        end
        default: begin
          data_d  = data_q;
          valid_d = valid_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : shift_stage

// File: rtl/shift_reg_bank.sv
// shift_reg_bank
//   DEPTH-stage, WIDTH-bit register bank with per-stage valid tracking.
//   Modes: hold, forward shift (sin_fwd -> stage 0 -> ... -> stage DEPTH-1),
//   reverse shift (sin_rev -> stage DEPTH-1 -> ... -> stage 0), parallel load.
//   Ports:
//     clk, rst_n  clock, async active-low reset
//     bus         shift_reg_bank_if.slave:
//                   in : en, clr, mode, sin_fwd, sin_rev, pload
//                   out: q_fwd (stage DEPTH-1), q_rev (stage 0), v_fwd, v_rev,
//                        count (popcount of valid), full, empty
//   Optional: SHIFT_REG_BANK_TAP_EN drives bus.taps / bus.tap_valid straight
//   from the stage registers.
module shift_reg_bank
  import shift_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  shift_reg_bank_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH-1:0] valid_w;
  mode_e            mode;
  logic [CW-1:0]    cnt;

  assign mode = mode_e'(bus.mode);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] fwd_data;
    logic             fwd_valid;
    logic [WIDTH-1:0] rev_data;
    logic             rev_valid;

    // Boundary stages take the serial inputs, which always enter as valid.
    if (g == 0) begin : g_head
      assign fwd_data  = bus.sin_fwd;
      assign fwd_valid = 1'b1;
    end else begin : g_fwd_nb
      assign fwd_data  = data_w[g-1];
      assign fwd_valid = valid_w[g-1];
    end

    if (g == DEPTH - 1) begin : g_tail
      assign rev_data  = bus.sin_rev;
      assign rev_valid = 1'b1;
    end else begin : g_rev_nb
      assign rev_data  = data_w[g+1];
      assign rev_valid = valid_w[g+1];
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (bus.clr),
      .en_i        (bus.en),
      .mode_i      (mode),
      .fwd_data_i  (fwd_data),
      .fwd_valid_i (fwd_valid),
      .rev_data_i  (rev_data),
      .rev_valid_i (rev_valid),
      .load_data_i (bus.pload[g*WIDTH +: WIDTH]),
      .data_o      (data_w[g]),
      .valid_o     (valid_w[g])
    );

`ifdef SHIFT_REG_BANK_TAP_EN
    assign bus.taps[g*WIDTH +: WIDTH] = data_w[g];
    assign bus.tap_valid[g]           = valid_w[g];
`endif
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt = cnt + CW'(valid_w[i]);
    end
  end

  assign bus.q_fwd = data_w[DEPTH-1];
  assign bus.q_rev = data_w[0];
  assign bus.v_fwd = valid_w[DEPTH-1];
  assign bus.v_rev = valid_w[0];
  assign bus.count = cnt;
  assign bus.full  = (cnt == CW'(DEPTH));
  assign bus.empty = (cnt == '0);

endmodule : shift_reg_bank

// File: tb/tb_shift_reg_bank.sv
module tb_shift_reg_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  shift_reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  shift_reg_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m,
                       input logic [7:0] sf, input logic [7:0] sr);
    bus.en      = e;
    bus.clr     = c;
    bus.mode    = m;
    bus.sin_fwd = sf;
    bus.sin_rev = sr;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] qf, input logic [7:0] qr,
                             input logic vf, input logic vr, input int cnt);
    check({tag, ".q_fwd"}, 32'(bus.q_fwd), 32'(qf));
    check({tag, ".q_rev"}, 32'(bus.q_rev), 32'(qr));
    check({tag, ".v_fwd"}, 32'(bus.v_fwd), 32'(vf));
    check({tag, ".v_rev"}, 32'(bus.v_rev), 32'(vr));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".full"},  32'(bus.full),  32'(cnt == 4));
    check({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
  endtask

  initial begin
    logic [7:0] fill [4];
    n_cmp = 0;
    n_bad = 0;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    rst_n     = 1'b0;
    bus.pload = '0;
    drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    tick();
    check_state("reset", 8'h00, 8'h00, 1'b0, 1'b0, 0);
    rst_n = 1'b1;

    // Idle hold with en=1, mode 00.
    drive(1'b1, 1'b0, 2'b00, 8'hFF, 8'hFF);
    for (int i = 0; i < 5; i++) tick();
    check_state("idle", 8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Forward fill: count 1..4, q_fwd only valid after the 4th edge.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'b01, fill[i], 8'h00);
      tick();
      check("fill.count", 32'(bus.count), 32'(i + 1));
      check("fill.v_fwd", 32'(bus.v_fwd), 32'(i == 3));
      check("fill.q_rev", 32'(bus.q_rev), 32'(fill[i]));
    end
    check_state("full", 8'h11, 8'h44, 1'b1, 1'b1, 4);

    // Saturation: oldest word dropped, count stays at DEPTH.
    drive(1'b1, 1'b0, 2'b01, 8'h55, 8'h00);
    tick();
    check_state("sat", 8'h22, 8'h55, 1'b1, 1'b1, 4);

    // Load stage0..3 = 44,33,22,11 then reverse shift with sin_rev AA.
    bus.pload = 32'h11223344;
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
    tick();
    check_state("ld1", 8'h11, 8'h44, 1'b1, 1'b1, 4);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 8'hAA);
    tick();
    check_state("rev", 8'hAA, 8'h33, 1'b1, 1'b1, 4);

    // Parallel load then en gating with mode 01.
    bus.pload = 32'hDDCCBBAA;
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
    tick();
    check_state("ld2", 8'hDD, 8'hAA, 1'b1, 1'b1, 4);
    drive(1'b0, 1'b0, 2'b01, 8'hEE, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("gate", 8'hDD, 8'hAA, 1'b1, 1'b1, 4);
    end

    // clr beats load in the same cycle.
    drive(1'b1, 1'b1, 2'b11, 8'h00, 8'h00);
    tick();
    check_state("clrld", 8'h00, 8'h00, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 2'b01, 8'h5A, 8'h00);
    tick();
    check_state("post_clr", 8'h00, 8'h5A, 1'b0, 1'b1, 1);

    // clr also beats en=0.
    drive(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
    tick();
    check_state("clr_noen", 8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Reverse latency from empty: 0x77 reaches q_rev after DEPTH reverse edges.
    drive(1'b1, 1'b0, 2'b10, 8'h00, 8'h77);
    tick();
    check_state("rv1", 8'h77, 8'h00, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 2'b10, 8'h00, 8'h01);
    tick();
    tick();
    check("rv3.v_rev", 32'(bus.v_rev), 32'd0);
    tick();
    check_state("rv4", 8'h01, 8'h77, 1'b1, 1'b1, 4);

    // Forward shift after reverse: valid bits travel, count stays bounded.
    drive(1'b1, 1'b0, 2'b01, 8'h99, 8'h00);
    tick();
    check_state("dirchg", 8'h01, 8'h99, 1'b1, 1'b1, 4);

    // Mode 00 with en=1 holds.
    drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    check_state("hold", 8'h01, 8'h99, 1'b1, 1'b1, 4);

`ifdef SHIFT_REG_BANK_TAP_EN
    bus.pload = 32'h0F1E2D3C;
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
    tick();
    check("taps", bus.taps, 32'h0F1E2D3C);
    check("tap_valid", 32'(bus.tap_valid), 32'hF);
`endif

    // Async reset between edges while full.
    bus.pload = 32'h12345678;
    drive(1'b1, 1'b0, 2'b11, 8'h00, 8'h00);
    tick();
    drive(1'b1, 1'b0, 2'b01, 8'hC3, 8'h00);
    #1;
    rst_n = 1'b0;
    #1;
    check_state("arst", 8'h00, 8'h00, 1'b0, 1'b0, 0);
    tick();
    check_state("arst_hold", 8'h00, 8'h00, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    tick();
    check_state("arst_rel", 8'h00, 8'hC3, 1'b0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_shift_reg_bank

// File: doc/shift_reg_bank.md
# shift_reg_bank

Parametrised multi-stage register bank, the next generation of the team's single D flip-flop: DEPTH stages of WIDTH-bit words with per-stage valid tracking, async active-low reset, and a mode input for hold, forward shift, reverse shift and parallel load. Used as a configurable delay line and serial/parallel converter between datapath blocks; every stage is built from the same D-register primitive with a clock enable and a next-state mux.

## Interface
- WIDTH, default 8: bits per stage (>=1).
- DEPTH, default 4: number of stages (>=2).
- CW, default $clog2(DEPTH+1): width of the occupancy count (localparam, not overridable).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- en  in  1  clock enable; 0 = hold regardless of mode.
- clr  in  1  synchronous clear; overrides en and mode.
- mode  in  2  00 hold, 01 shift forward, 10 shift reverse, 11 parallel load.
- sin_fwd  in  WIDTH  word entering stage 0 on a forward shift.
- sin_rev  in  WIDTH  word entering stage DEPTH-1 on a reverse shift.
- pload  in  WIDTH*DEPTH  parallel load data; stage i = pload[i*WIDTH +: WIDTH].
- q_fwd  out  WIDTH  data of stage DEPTH-1.
- q_rev  out  WIDTH  data of stage 0.
- v_fwd  out  1  valid of stage DEPTH-1.
- v_rev  out  1  valid of stage 0.
- count  out  CW  number of valid stages (popcount).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- State per stage i: data[i] (WIDTH), valid[i] (1).
- Priority per edge: rst_n low > clr > !en (hold) > mode.
- clr=1: all data = 0, all valid = 0.
- mode 00: all stages hold.
- mode 01: data[i] <= data[i-1], valid[i] <= valid[i-1] for i>=1; data[0] <= sin_fwd, valid[0] <= 1. Old stage DEPTH-1 discarded.
- mode 10: data[i] <= data[i+1], valid[i] <= valid[i+1] for i<=DEPTH-2; data[DEPTH-1] <= sin_rev, valid[DEPTH-1] <= 1. Old stage 0 discarded.
- mode 11: data[i] <= pload slice i; all valid <= 1.
- count, full, empty: combinational from registered valid bits; no extra latency.
- Outputs q_*/v_* are direct register outputs (no combinational path from inputs).

## Timing
- Reset (async assert, any time, including mid-shift): all data 0, all valid 0, count 0, empty 1, full 0, q_* 0, v_* 0. Deassertion assumed synchronous to clk externally.
- Forward latency: sin_fwd appears on q_fwd exactly DEPTH enabled forward-shift edges after capture; edges with en=0 or mode 00 do not advance.
- Reverse symmetric: sin_rev reaches q_rev after DEPTH reverse edges.
- Parallel load visible on all outputs the cycle after the edge.
- Saturation: forward shifts on a full bank keep count = DEPTH; oldest word lost, no error flag.
- Direction change mid-stream is legal; valid bits move with data, so count never exceeds DEPTH nor goes negative.
- clr and mode 11 in the same cycle: clr wins (bank empty).

## Configuration
- SHIFT_REG_BANK_TAP_EN defined: adds outputs taps (WIDTH*DEPTH, stage i at [i*WIDTH +: WIDTH]) and tap_valid (DEPTH), direct from stage registers.
- Undefined: those ports do not exist; all other behaviour identical.

## Structure
- Package shift_reg_bank_pkg: mode constants MODE_HOLD=2'b00, MODE_FWD=2'b01, MODE_REV=2'b10, MODE_LOAD=2'b11.
- Sub-module shift_stage: one data+valid register with async active-low reset, clr, en and 4-way next-state mux (hold / fwd neighbour / rev neighbour / load); top level instantiates DEPTH copies in a generate loop and wires neighbours, with boundary stages fed from sin_fwd / sin_rev.
- Popcount for count in the top level.

## Test plan
- Reset then idle: rst_n low 2 cycles -> count 0, empty 1, q_fwd 0, v_fwd 0; hold 5 cycles, unchanged.
- Forward fill (WIDTH 8, DEPTH 4): shift 0x11,0x22,0x33,0x44 -> count 1..4, full after 4th edge, q_fwd 0x11; one more shift 0x55 -> q_fwd 0x22, count stays 4.
- Reverse after forward: from full bank 0x44,0x33,0x22,0x11 (stage 0..3), one reverse shift with sin_rev 0xAA -> q_rev 0x33, q_fwd 0xAA, count 4.
- Parallel load then en gating: load 0xDDCCBBAA -> q_rev 0xAA, q_fwd 0xDD, full; en=0 with mode 01 for 3 cycles -> no change.
- clr vs load: clr=1 and mode 11 same cycle -> empty 1, all q 0; next cycle mode 01 sin_fwd 0x5A -> count 1, v_rev 1, v_fwd 0.
- Async reset mid-shift: assert rst_n low between edges while full -> outputs 0 immediately, before next clk edge.
